mp_add16_seq: RTL and testbench

- Multi-precision add sequencer sitting directly upstream of csa_16.
- Accepts a stream of 16-bit operand word pairs, least-significant word first, over a valid/ready handshake, and drives each pair into one internal csa_16 instance.
- Chains the adder's carry-out into the next word's carry-in through a register.
- Presents registered sum words plus the final carry to a downstream consumer.

---
 rtl/mp_add16_seq.sv | 161 ++++++++++++++++
 tb/tb_mp_add16_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_add16_seq.sv
// Multi-precision add sequencer: streams 16-bit word pairs LSW-first through a carry-select adder,
// chaining carries across words. Optional build macro MP_ADD16_OVF_FLAG_EN adds the ovf output.

module csa_16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);
    // Four 4-bit blocks; each upper block precomputes both carry-in cases and the chain only muxes.
    logic [3:0][3:0] sum0;
    logic [3:0][3:0] sum1;
    logic [3:0]      c0;
    logic [3:0]      c1;
    logic [4:0]      blk_c;

    // NOTE: every signal driven in always_comb gets a default first so no path can infer a latch.
    always_comb begin
        sum0  = '0;
        sum1  = '0;
        c0    = '0;
        c1    = '0;
        blk_c = '0;
        s     = '0;
        for (int i = 0; i < 4; i++) begin
            {c0[i], sum0[i]} = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]};
            {c1[i], sum1[i]} = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + 5'd1;
        end
        blk_c[0] = cin;
        for (int i = 0; i < 4; i++) begin
            s[4*i +: 4]  = blk_c[i] ? sum1[i] : sum0[i];
            blk_c[i + 1] = blk_c[i] ? c1[i] : c0[i];
        end
    end

    assign cout = blk_c[4];
endmodule

module mp_add16_seq #(
    parameter int WIDTH     = 16,
    parameter int MAX_WORDS = 8,
    localparam int IDX_W    = $clog2(MAX_WORDS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      a,
    input  logic [15:0]      b,
    input  logic             cin_init,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      s,
    output logic             cout,
    output logic             out_last,
    output logic [IDX_W-1:0] out_idx,
`ifdef MP_ADD16_OVF_FLAG_EN
    output logic             ovf,
`endif
    output logic             out_err
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_WORDS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] word_cnt;
    logic [IDX_W-1:0] word_cnt_nxt;
    logic             carry_q;
    logic             carry_nxt;

    logic             accept;
    logic             add_cin;
    logic [15:0]      add_s;
    logic             add_cout;
    logic             err_term;
    logic             word_last;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign add_cin  = (state == RUN) ? carry_q : cin_init;

    // Running out of word slots without in_last closes the operand as an error.
    assign err_term  = !in_last && (word_cnt == LAST_IDX);
    assign word_last = in_last || err_term;

    csa_16 u_csa (
        .a    (a),
        .b    (b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_cout)
    );

    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        carry_nxt    = carry_q;
        if (accept) begin
            if (word_last) begin
                state_nxt    = IDLE;
                word_cnt_nxt = '0;
                carry_nxt    = 1'b0;
            end else begin
                state_nxt    = RUN;
                word_cnt_nxt = word_cnt + IDX_W'(1);
                carry_nxt    = add_cout;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            word_cnt <= '0;
            carry_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            word_cnt <= word_cnt_nxt;
            carry_q  <= carry_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            out_last  <= 1'b0;
            out_idx   <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            s         <= add_s;
            cout      <= word_last && add_cout;
            out_last  <= word_last;
            out_idx   <= word_cnt;
            out_err   <= err_term;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MP_ADD16_OVF_FLAG_EN
    // Signed overflow of the whole operand is decided by the MS word alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= word_last && (a[15] == b[15]) && (add_s[15] != a[15]);
        end
    end
`endif
endmodule

// File: tb/tb_mp_add16_seq.sv
// Directed bench for mp_add16_seq: single word, carry chain, backpressure, MAX_WORDS error, mid-operand reset.
// Inputs are driven and outputs sampled on the falling edge.

module tb_mp_add16_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin_init;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        out_last;
    logic [2:0]  out_idx;
    logic        out_err;
`ifdef MP_ADD16_OVF_FLAG_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;

    mp_add16_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin_init  (cin_init),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .out_last  (out_last),
        .out_idx   (out_idx),
`ifdef MP_ADD16_OVF_FLAG_EN
        .ovf       (ovf),
`endif
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Packed view {out_valid, s, cout, out_last, out_idx, out_err}.
    function automatic logic [22:0] obs();
        return {out_valid, s, cout, out_last, out_idx, out_err};
    endfunction

    task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vc, input logic vl);
        a        = va;
        b        = vb;
        cin_init = vc;
        in_last  = vl;
        in_valid = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin_init  = 1'b0;
        in_last   = 1'b0;
        #3;
        total++;
        if (obs() !== 23'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=%h", obs(), 23'h0);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [22:0] exp;
        drive(16'h99CD, 16'h36D6, 1'b0, 1'b1);
        @(negedge clk);
        exp = {1'b1, 16'hD0A3, 1'b0, 1'b1, 3'd0, 1'b0};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL single_cin0 got=%h exp=%h", obs(), exp);
        end
        drive(16'h99CD, 16'h36D6, 1'b1, 1'b1);
        @(negedge clk);
        exp = {1'b1, 16'hD0A4, 1'b0, 1'b1, 3'd0, 1'b0};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL single_cin1 got=%h exp=%h", obs(), exp);
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_drain got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_chain();
        logic [22:0] exp;
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        exp = {1'b1, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL chain_w0 got=%h exp=%h", obs(), exp);
        end
        // cin_init must be ignored on a non-first word.
        drive(16'h0000, 16'h0000, 1'b1, 1'b1);
        @(negedge clk);
        exp = {1'b1, 16'h0001, 1'b0, 1'b1, 3'd1, 1'b0};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL chain_w1 got=%h exp=%h", obs(), exp);
        end
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        exp = {1'b1, 16'h0000, 1'b1, 1'b1, 3'd0, 1'b0};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL chain_new_op got=%h exp=%h", obs(), exp);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [22:0] exp;
        out_ready = 1'b0;
        drive(16'h8000, 16'h8000, 1'b0, 1'b0);
        @(negedge clk);
        exp = {1'b1, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0};
        drive(16'h1234, 16'h0001, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (obs() !== exp || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got=%h rdy=%b exp=%h rdy=0", i, obs(), in_ready, exp);
            end
            @(negedge clk);
        end
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL bp_w0_before_release got=%h exp=%h", obs(), exp);
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release_ready got=%b exp=1", in_ready);
        end
        @(negedge clk);
        exp = {1'b1, 16'h1236, 1'b0, 1'b1, 3'd1, 1'b0};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL bp_w1 got=%h exp=%h", obs(), exp);
        end
        in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_drain got=%b exp=0", out_valid);
        end
    endtask

    task automatic test_max_words();
        logic [22:0] exp;
        for (int i = 0; i < 8; i++) begin
            drive(16'hFFFF, 16'h0000, 1'b1, 1'b0);
            @(negedge clk);
            exp = {1'b1, 16'h0000, (i == 7), (i == 7), 3'(i), (i == 7)};
            total++;
            if (obs() !== exp) begin
                bad++;
                $display("FAIL max_w%0d got=%h exp=%h", i, obs(), exp);
            end
        end
        drive(16'h0001, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        exp = {1'b1, 16'h0002, 1'b0, 1'b1, 3'd0, 1'b0};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL max_restart got=%h exp=%h", obs(), exp);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [22:0] exp;
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        drive(16'hFFFF, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        exp = {1'b1, 16'h0000, 1'b0, 1'b0, 3'd1, 1'b0};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL rst_mid_w1 got=%h exp=%h", obs(), exp);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (obs() !== 23'h0) begin
            bad++;
            $display("FAIL rst_mid_async got=%h exp=%h", obs(), 23'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // A stale carry_q of 1 would make this 0x0003.
        drive(16'h0001, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        exp = {1'b1, 16'h0002, 1'b0, 1'b1, 3'd0, 1'b0};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL rst_mid_restart got=%h exp=%h", obs(), exp);
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ovf();
        logic [22:0] exp;
        drive(16'h7FFF, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        exp = {1'b1, 16'h8000, 1'b0, 1'b1, 3'd0, 1'b0};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL ovf_pos got=%h exp=%h", obs(), exp);
        end
`ifdef MP_ADD16_OVF_FLAG_EN
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_pos_flag got=%b exp=1", ovf);
        end
`endif
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
        @(negedge clk);
        exp = {1'b1, 16'h0000, 1'b1, 1'b1, 3'd0, 1'b0};
        total++;
        if (obs() !== exp) begin
            bad++;
            $display("FAIL ovf_neg got=%h exp=%h", obs(), exp);
        end
`ifdef MP_ADD16_OVF_FLAG_EN
        total++;
        if (ovf !== 1'b0) begin
            bad++;
            $display("FAIL ovf_neg_flag got=%b exp=0", ovf);
        end
`endif
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_chain();
        test_backpressure();
        test_max_words();
        test_reset_mid();
        test_ovf();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
